// File: rtl/uart_receiver.sv
// uart_receiver
//   Receive endpoint of an RTS/CTS-flow-controlled UART link. A one-entry
//   holding register buffers the received word. CTS is granted only while
//   that register is empty, so an unread word can never be overwritten.
//   Frame format: start bit, DATA_BITS data bits LSB first, one stop bit.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   rx           serial line, idle high, asynchronous to clk
//   rts          request-to-send from the remote transmitter
//   cts          clear-to-send, registered, high only while in GRANT
//   rx_data      received word, valid while rx_valid=1
//   rx_valid     holding register full
//   rx_ready     consumer accepts rx_data when rx_valid=1
//   frame_err    one-cycle pulse when the stop bit is sampled low
//   timeout_err  one-cycle pulse when the grant expires with no start bit
//   current      FSM state encoding, for debug
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int TIMEOUT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rts,
    output logic                 cts,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 timeout_err,
    output logic [2:0]           current
);

    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W     = $clog2(TO_CYCLES + 1);
    localparam int BIT_W     = $clog2(DATA_BITS + 1);

    // Terminal counts: each phase ends on the cycle the counter hits *_LAST.
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        GRANT = 3'b001,
        START = 3'b010,
        DATA  = 3'b011,
        STOP  = 3'b100
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 timeout_err_reg, timeout_err_next;
    logic                 cts_reg;

    // Two-flop synchroniser plus one delay stage for edge detection.
    logic rx_meta_reg, rx_s_reg, rx_prev_reg;
    logic rx_fall;

    assign rx_fall = rx_prev_reg & ~rx_s_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg     <= 1'b1;
            rx_s_reg        <= 1'b1;
            rx_prev_reg     <= 1'b1;
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            cts_reg         <= 1'b0;
        end else begin
            rx_meta_reg     <= rx;
            rx_s_reg        <= rx_meta_reg;
            rx_prev_reg     <= rx_s_reg;
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            rx_data_reg     <= rx_data_next;
            rx_valid_reg    <= rx_valid_next;
            frame_err_reg   <= frame_err_next;
            timeout_err_reg <= timeout_err_next;
            // Deriving cts from the next state keeps it high exactly while
            // the FSM sits in GRANT.
            cts_reg         <= (state_next == GRANT);
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        rx_data_next     = rx_data_reg;
        rx_valid_next    = rx_valid_reg;
        frame_err_next   = 1'b0;
        timeout_err_next = 1'b0;

        // Consumer handshake; a STOP-state load below cannot coincide with
        // this because a frame is only accepted while the register is empty.
        if (rx_valid_reg && rx_ready) begin
            rx_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (rts && !rx_valid_reg) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // A start edge wins over a simultaneous expiry.
                if (rx_fall) begin
                    state_next   = START;
                    cnt_next     = '0;
                    bit_cnt_next = '0;
                end else if (cnt_reg == TO_LAST) begin
                    state_next       = IDLE;
                    cnt_next         = '0;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    // Line back high at mid start bit: glitch, re-arm grant.
                    state_next = rx_s_reg ? GRANT : DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt_reg == DATA_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_s_reg) begin
                        rx_data_next  = shift_reg;
                        rx_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign cts         = cts_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign frame_err   = frame_err_reg;
    assign timeout_err = timeout_err_reg;
    assign current     = state_reg;

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int C  = 16;
    localparam int DB = 8;
    localparam int TB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          rts = 1'b0;
    logic          rx_ready = 1'b0;
    logic          cts;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          timeout_err;
    logic [2:0]    current;

    int vectors = 0;
    int miscompares = 0;

    // Event counters maintained by the monitor; main block only reads them.
    int fe_cnt = 0;
    int to_cnt = 0;
    int cts_hi_in_frame = 0;
    logic in_frame = 1'b0;

    logic [DB-1:0] exp_q[$];

    uart_receiver #(
        .CLKS_PER_BIT(C),
        .DATA_BITS(DB),
        .TIMEOUT_BITS(TB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rts(rts),
        .cts(cts),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .timeout_err(timeout_err),
        .current(current)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (timeout_err) to_cnt++;
        if (in_frame && cts) cts_hi_in_frame++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Advance one cycle; the #1 lets the negedge monitor settle first.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(C);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        if (stop) exp_q.push_back(d);
        drive_bit(1'b0);
        in_frame = 1'b1;
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(stop);
        in_frame = 1'b0;
        rx = 1'b1;
    endtask

    // Bounded wait for rx_valid, then compare against the scoreboard head.
    task automatic expect_word(input string tag);
        logic [DB-1:0] exp;
        for (int i = 0; i < 60 && !rx_valid; i++) tick();
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            $display("word %s: rx_data=0x%02h expected=0x%02h", tag, rx_data, exp);
            check({tag, "_data"}, 32'(rx_data), 32'(exp));
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        int fe_base, to_base, cts_base, n, hi, non_idle;

        // Reset
        tick(3);
        rst = 1'b0;
        check("rst_cts", 32'(cts), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(current), 32'd0);
        // A low line in IDLE must not start anything.
        rx = 1'b0;
        tick(12);
        check("idle_low_state", 32'(current), 32'd0);
        rx = 1'b1;
        tick(4);

        // 1. Nominal frame
        fe_base = fe_cnt;
        cts_base = cts_hi_in_frame;
        rts = 1'b1;
        tick();
        check("t1_cts", 32'(cts), 32'd1);
        check("t1_state", 32'(current), 32'd1);
        rts = 1'b0;
        send_frame(8'hA5, 1'b1);
        expect_word("t1");
        check("t1_cts_frame", 32'(cts_hi_in_frame - cts_base), 32'd0);
        check("t1_ferr", 32'(fe_cnt - fe_base), 32'd0);

        // 2. Back-pressure
        rts = 1'b1;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cts) hi++;
        end
        check("t2_cts_held", 32'(hi), 32'd0);
        check("t2_valid_held", 32'(rx_valid), 32'd1);
        check("t2_data_held", 32'(rx_data), 32'hA5);
        consume();
        check("t2_valid_clr", 32'(rx_valid), 32'd0);
        check("t2_cts_not_yet", 32'(cts), 32'd0);
        tick();
        check("t2_cts", 32'(cts), 32'd1);
        rts = 1'b0;

        // 3. Bad stop bit (uses the grant from step 2)
        fe_base = fe_cnt;
        send_frame(8'h3C, 1'b0);
        tick(5);
        check("t3_ferr", 32'(fe_cnt - fe_base), 32'd1);
        check("t3_valid", 32'(rx_valid), 32'd0);
        check("t3_data", 32'(rx_data), 32'hA5);
        check("t3_state", 32'(current), 32'd0);

        // 4. False start
        rts = 1'b1;
        tick();
        rts = 1'b0;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(14);
        check("t4_state", 32'(current), 32'd1);
        check("t4_cts", 32'(cts), 32'd1);
        check("t4_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h81, 1'b1);
        expect_word("t4");
        consume();

        // 5. Grant timeout
        to_base = to_cnt;
        rts = 1'b1;
        tick();
        rts = 1'b0;
        check("t5_grant", 32'(current), 32'd1);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (timeout_err) begin
                n = i;
                break;
            end
        end
        check("t5_delay", 32'(n), 32'd64);
        tick(3);
        check("t5_pulses", 32'(to_cnt - to_base), 32'd1);
        check("t5_cts", 32'(cts), 32'd0);
        check("t5_state", 32'(current), 32'd0);

        // 6. Reset mid-frame (0x3C, reset during bit 3)
        rts = 1'b1;
        tick();
        rts = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b1;
        tick(C / 2);
        check("t6_in_data", 32'(current), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_cts", 32'(cts), 32'd0);
        check("t6_valid", 32'(rx_valid), 32'd0);
        check("t6_data", 32'(rx_data), 32'd0);
        check("t6_state", 32'(current), 32'd0);
        fe_base = fe_cnt;
        non_idle = 0;
        rx = 1'b1;
        for (int i = 0; i < C / 2; i++) begin
            tick();
            if (current != 3'd0 || rx_valid) non_idle++;
        end
        for (int b = 0; b < 5; b++) begin
            rx = (b < 2) ? 1'b1 : ((b < 4) ? 1'b0 : 1'b1);
            for (int i = 0; i < C; i++) begin
                tick();
                if (current != 3'd0 || rx_valid) non_idle++;
            end
        end
        check("t6_ignored", 32'(non_idle), 32'd0);
        check("t6_ferr", 32'(fe_cnt - fe_base), 32'd0);
        // Recovery
        rts = 1'b1;
        tick();
        rts = 1'b0;
        check("t6_regrant", 32'(cts), 32'd1);
        send_frame(8'h5A, 1'b1);
        expect_word("t6");
        consume();
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side endpoint of the UART link; pairs with the transmitter's RTS/CTS state machine.
- Grants CTS in response to RTS when its one-entry holding register is empty.
- Deserialises one frame: start bit, DATA_BITS data bits LSB first, one stop bit.
- Presents the received word on a valid/ready interface to the consumer.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); must be ≥ 4
DATA_BITS, 8, data bits per frame (5..9)
TIMEOUT_BITS, 4, bit periods to wait for a start bit after granting CTS

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
rts  input  1  request-to-send from the remote transmitter
cts  output  1  clear-to-send to the remote transmitter (registered)
rx_data  output  DATA_BITS  received word, valid while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid=1
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
timeout_err  output  1  one-cycle pulse when the grant expires with no start bit
current  output  3  state encoding, for debug

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk. rst has priority over all other inputs.
- Reset values: cts=0, rx_valid=0, rx_data=0, frame_err=0, timeout_err=0, current=IDLE (3'b000). The rx synchroniser resets to 1, and all counters reset to 0.
- rx input: passes through a 2-flop synchroniser. All sampling and edge detection use the synchronised signal rx_s. Edge detection compares rx_s with its previous value.
- States:
  - IDLE=000
  - GRANT=001
  - START=010
  - DATA=011
  - STOP=100
  - Any other encoding goes to IDLE on the next cycle.
- IDLE:
  - If rts=1 and rx_valid=0, go to GRANT. cts=1 from the next cycle.
  - Otherwise stay in IDLE with cts=0.
- GRANT:
  - cts=1 throughout.
  - The timeout counter counts TIMEOUT_BITS*CLKS_PER_BIT cycles.
  - On a falling edge of rx_s: go to START, cts=0 from the next cycle, bit counter cleared.
  - On expiry with no edge: timeout_err=1 for one cycle, cts=0, go to IDLE.
  - Start bits are recognised only in GRANT. A low rx seen in IDLE is ignored.
- START:
  - After CLKS_PER_BIT/2 cycles (integer division), sample rx_s.
  - If 0, go to DATA with the baud counter cleared.
  - If 1, it is a false start: return to GRANT, cts=1, timeout counter restarted.
- DATA:
  - Sample rx_s every CLKS_PER_BIT cycles, at the bit centre.
  - Shift into a shift register LSB first: the first sampled bit becomes rx_data[0].
  - After DATA_BITS samples, go to STOP.
- STOP:
  - Sample rx_s after CLKS_PER_BIT cycles.
  - If 1: load rx_data from the shift register and set rx_valid=1 on the next cycle.
  - If 0: frame_err=1 for one cycle, word discarded, rx_valid unchanged.
  - Either way, go to IDLE.
- Holding register handshake:
  - rx_valid stays 1 and rx_data stays stable until the cycle in which rx_valid=1 and rx_ready=1. rx_valid=0 from the following cycle.
  - rx_ready while rx_valid=0 has no effect.
  - A new grant requires rx_valid=0. If rts is already high on the cycle rx_valid clears, cts rises on the next cycle.
  - A new frame can therefore never overwrite an unread word; no overrun condition exists.
- Latency:
  - rx pin to internal sampling: 2 cycles.
  - Stop-bit centre sample to rx_valid=1: 1 cycle.
  - rts rising (with rx_valid=0) to cts=1: 1 cycle.
- cts is never high outside GRANT.
- Reset mid-frame: the partial word is discarded, outputs return to reset values, and the state returns to IDLE on the next edge.
- rts falling while in GRANT: no effect. The grant remains until a start bit or the timeout.

Test Plan:
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, TIMEOUT_BITS=4.
1. Nominal frame:
   - Stimulus: rx_valid=0, rts=1 → cts=1 one cycle later. Send start, 0xA5 LSB first, stop.
   - Required: cts=0 throughout the frame; rx_data=8'hA5 and rx_valid=1 about 1 cycle after the stop-bit centre (plus the 2-cycle sync); frame_err=0.
2. Back-pressure:
   - Stimulus: leave 0xA5 unread with rx_ready=0 and raise rts.
   - Required: cts stays 0 for 100 cycles. Pulse rx_ready=1 for one cycle → rx_valid=0 next cycle, cts=1 the cycle after.
3. Bad stop bit:
   - Stimulus: send 0x3C with the stop bit held low.
   - Required: exactly one frame_err pulse; rx_valid stays 0; rx_data unchanged; current=IDLE.
4. False start:
   - Stimulus: in GRANT, drive rx low for 4 clk only.
   - Required: current returns to GRANT; cts=1; rx_valid=0. A following valid 0x81 frame is received correctly.
5. Grant timeout:
   - Stimulus: rts=1 for 1 cycle, rx held high.
   - Required: timeout_err pulses once 64 cycles after entering GRANT; cts=0 afterwards; current=IDLE.
6. Reset mid-frame:
   - Stimulus: assert rst for 1 cycle during data bit 3.
   - Required: next cycle cts=0, rx_valid=0, rx_data=0, current=IDLE. The remaining line activity is ignored until rts is raised again.
